dff_to_jkff: RTL and testbench

DFF_TO_JKFF -- requirements
Module: dff_to_jkff

---
 rtl/dff_to_jkff_pkg.sv | 9 +
 rtl/dff_to_jkff_if.sv | 10 +
 rtl/dff_to_jkff_d_ff.sv | 22 ++
 rtl/dff_to_jkff.sv | 29 ++
 tb/tb_dff_to_jkff.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/dff_to_jkff_pkg.sv
// Shared helpers for the JK flip-flop built from a D flip-flop.
package dff_to_jkff_pkg;

   // JK characteristic equation evaluated against the current stored state.
   function automatic logic jk_next(input logic j, input logic k, input logic q);
      return (j & ~q) | (~k & q);
   endfunction

endpackage

// File: rtl/dff_to_jkff_if.sv
// Bundle of the JK control inputs and the flip-flop state outputs.
interface dff_to_jkff_if;
   logic j;
   logic k;
   logic q;
   logic qbar;

   modport master (output j, output k, input q, input qbar);
   modport slave  (input j, input k, output q, output qbar);
endinterface

// File: rtl/dff_to_jkff_d_ff.sv
// Single-bit storage element with synchronous active-high clear.
module d_ff (
   input  logic d,
   input  logic clk,
   input  logic rst,
   output logic q
);

   logic q_q;

   // State register: clear on rst, otherwise capture d.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/dff_to_jkff.sv
// JK flip-flop: combinational JK next-state logic feeding one d_ff, plus qbar inverter.
module dff_to_jkff
   import dff_to_jkff_pkg::*;
(
   input  logic j,
   input  logic k,
   input  logic clk,
   input  logic rst,
   output logic q,
   output logic qbar
);

   logic d_s;
   logic q_s;

   assign d_s = jk_next(j, k, q_s);

   d_ff u_d_ff (
      .d   (d_s),
      .clk (clk),
      .rst (rst),
      .q   (q_s)
   );

   // qbar derives from the single stored bit so it can never disagree with q.
   assign q    = q_s;
   assign qbar = ~q_s;

endmodule

// File: tb/tb_dff_to_jkff.sv
// Scoreboard bench for dff_to_jkff: expected q pushed per edge, popped after it.
module tb_dff_to_jkff;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic exp_q[$];
   logic model_q;

   dff_to_jkff_if bus ();

   dff_to_jkff dut (
      .j    (bus.j),
      .k    (bus.k),
      .clk  (clk),
      .rst  (rst),
      .q    (bus.q),
      .qbar (bus.qbar)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      total = total + 1;
      if (obs !== expv) begin
         bad = bad + 1;
         $display("FAIL %s: got %b expected %b", tag, obs, expv);
      end
   endtask

   // Reference behaviour written as the JK truth table, independent of the RTL equation.
   function automatic logic model_next(input logic cur, input logic jj, input logic kk, input logic rr);
      if (rr) return 1'b0;
      case ({jj, kk})
         2'b00:   return cur;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~cur;
      endcase
   endfunction

   // Predict the next state from inputs present now, let one rising edge pass, compare.
   task automatic step(input string tag);
      logic e;
      model_q = model_next(model_q, bus.j, bus.k, rst);
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_bit({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
         e = exp_q.pop_front();
         check_bit({tag, "_q"}, bus.q, e);
         check_bit({tag, "_qbar"}, bus.qbar, ~e);
      end
   endtask

   task automatic drive(input logic jj, input logic kk, input logic rr);
      bus.j = jj;
      bus.k = kk;
      rst   = rr;
   endtask

   logic seq_j[6];
   logic seq_k[6];

   initial begin
      total   = 0;
      bad     = 0;
      model_q = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      @(negedge clk);

      // Reset with toggle request present
      step("reset");
      drive(1'b0, 1'b0, 1'b1);
      step("reset2");

      // Set then clear
      drive(1'b1, 1'b0, 1'b0); step("set");
      drive(1'b0, 1'b1, 1'b0); step("clear");

      // Toggle for four edges: 1,0,1,0
      drive(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step("toggle");

      // Hold from 0, set, hold from 1
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("hold0");
      drive(1'b1, 1'b0, 1'b0); step("set_h");
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("hold1");

      // Inputs changed between edges must not reach q until the next edge
      drive(1'b0, 1'b1, 1'b0);
      #3;
      check_bit("between_q", bus.q, 1'b1);
      step("between_edge");

      // Negedge stimulus: j at one falling edge, k at the next
      seq_j = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      seq_k = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.j = seq_j[i];
         step("neg_j");
         @(negedge clk);
         bus.k = seq_k[i];
         step("neg_k");
      end

      // Reset in the middle of a toggle run
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0);
      step("mt_tog1");
      step("mt_tog2");
      step("mt_tog3");
      drive(1'b1, 1'b1, 1'b1); step("mt_rst");
      drive(1'b1, 1'b1, 1'b0); step("mt_resume");
      step("mt_resume2");

      // Random traffic including occasional reset
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
